qram_row_sequencer: RTL and testbench

//  Upstream access controller for an array of CellOfQRAM bit cells (ROWS rows x WIDTH bits).

---
 rtl/qram_row_sequencer_pkg.sv | 24 ++
 rtl/qram_refresh_timer.sv | 43 ++++
 rtl/qram_row_sequencer.sv | 168 ++++++++++++++++
 tb/tb_qram_row_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qram_row_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : qram_row_sequencer_pkg
// Brief  : FSM state encoding and default array geometry for the row sequencer.
// Rev    : 1.0
// ============================================================================
package qram_row_sequencer_pkg;

   localparam int DEFAULT_ROWS   = 16;
   localparam int DEFAULT_ADDR_W = 4;
   localparam int DEFAULT_WIDTH  = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_DRIVE     = 3'd2,
      ST_RESP      = 3'd3,
      ST_REF_DRIVE = 3'd4,
      ST_REF_GAP   = 3'd5,
      ST_REF_LOAD  = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/qram_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module : qram_refresh_timer
// Brief  : Free-running refresh tick counter with pending and sticky overrun.
// Rev    : 1.0
// ============================================================================
module qram_refresh_timer #(
   parameter int REFRESH_INTERVAL = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic refresh_start,
   output logic pending,
   output logic overrun
);

   localparam int               CNT_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

   logic [CNT_W-1:0] count;
   logic             wrap;

   assign wrap = (count == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         count <= wrap ? '0 : count + 1'b1;
         // A tick always wins over a same-cycle clear so no refresh is lost.
         if (wrap) begin
            pending <= 1'b1;
            overrun <= overrun | pending;
         end else if (refresh_start) begin
            pending <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/qram_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module : qram_row_sequencer
// Brief  : Request/refresh sequencer driving one-hot load/drive row strobes.
// Rev    : 1.0
// ============================================================================
module qram_row_sequencer
   import qram_row_sequencer_pkg::*;
#(
   parameter int ROWS             = DEFAULT_ROWS,
   parameter int ADDR_W           = DEFAULT_ADDR_W,
   parameter int WIDTH            = DEFAULT_WIDTH,
   parameter int PULSE_CYCLES     = 2,
   parameter int REFRESH_INTERVAL = 64
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [WIDTH-1:0]  ReqData,
   output logic              RspValid,
   output logic [WIDTH-1:0]  RspData,
   output logic              RspError,
   output logic [ROWS-1:0]   RowLoadEdge,
   output logic [ROWS-1:0]   RowDriveEdge,
   output logic [WIDTH-1:0]  ArrayInData,
   input  logic [WIDTH-1:0]  ArrayOutData,
   output logic              RefreshOverrun
);

   localparam int                PCNT_W     = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);
   localparam int                ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [31:0]       ROWS_U     = ROWS;

   state_t              state, state_nxt;
   logic [PCNT_W-1:0]   pulse_cnt, pulse_cnt_nxt;
   logic                pulse_last;
   logic [ADDR_W-1:0]   req_addr;
   logic [WIDTH-1:0]    req_data;
   logic [WIDTH-1:0]    rd_data;
   logic                rsp_err;
   logic [ROW_W-1:0]    ref_ptr;
   logic [WIDTH-1:0]    ref_buf;
   logic                refresh_pending;
   logic                refresh_start;
   logic                accept;
   logic                addr_bad;
   logic [ROWS-1:0]     req_onehot;
   logic [ROWS-1:0]     ref_onehot;

   qram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_timer (
      .clk           (Clock),
      .rst           (Reset),
      .refresh_start (refresh_start),
      .pending       (refresh_pending),
      .overrun       (RefreshOverrun)
   );

   assign pulse_last = (pulse_cnt == PULSE_LAST);
   assign addr_bad   = (32'(ReqAddr) >= ROWS_U);
   assign accept     = (state == ST_IDLE) && !refresh_pending && ReqValid;
   assign ReqReady   = (state == ST_IDLE) && !refresh_pending && !Reset;
   assign req_onehot = ROWS'(1) << req_addr;
   assign ref_onehot = ROWS'(1) << ref_ptr;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= ST_IDLE;
         pulse_cnt <= '0;
         req_addr  <= '0;
         req_data  <= '0;
         rd_data   <= '0;
         rsp_err   <= 1'b0;
         ref_ptr   <= '0;
         ref_buf   <= '0;
      end else begin
         state     <= state_nxt;
         pulse_cnt <= pulse_cnt_nxt;
         if (accept) begin
            req_addr <= ReqAddr;
            req_data <= ReqData;
            rd_data  <= '0;
            rsp_err  <= addr_bad;
         end
         if (state == ST_DRIVE && pulse_last) begin
            rd_data <= ArrayOutData;
         end
         if (state == ST_REF_DRIVE && pulse_last) begin
            ref_buf <= ArrayOutData;
         end
         if (refresh_start) begin
            ref_ptr <= (ref_ptr == ROW_LAST) ? '0 : ref_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      pulse_cnt_nxt = pulse_cnt;
      refresh_start = 1'b0;
      case (state)
         ST_IDLE: begin
            pulse_cnt_nxt = '0;
            // Pending refresh holds off new requests until the row is restored.
            if (refresh_pending) begin
               state_nxt = ST_REF_DRIVE;
            end else if (accept) begin
               if (addr_bad) begin
                  state_nxt = ST_RESP;
               end else if (ReqWrite) begin
                  state_nxt = ST_LOAD;
               end else begin
                  state_nxt = ST_DRIVE;
               end
            end
         end
         ST_LOAD, ST_DRIVE, ST_REF_DRIVE, ST_REF_LOAD: begin
            if (!pulse_last) begin
               pulse_cnt_nxt = pulse_cnt + 1'b1;
            end else begin
               pulse_cnt_nxt = '0;
               if (state == ST_REF_DRIVE) begin
                  state_nxt = ST_REF_GAP;
               end else if (state == ST_REF_LOAD) begin
                  state_nxt     = ST_IDLE;
                  refresh_start = 1'b1;
               end else begin
                  state_nxt = ST_RESP;
               end
            end
         end
         ST_REF_GAP: state_nxt = ST_REF_LOAD;
         ST_RESP:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      RowLoadEdge  = '0;
      RowDriveEdge = '0;
      ArrayInData  = '0;
      case (state)
         ST_LOAD: begin
            RowLoadEdge = req_onehot;
            ArrayInData = req_data;
         end
         ST_DRIVE:     RowDriveEdge = req_onehot;
         ST_REF_DRIVE: RowDriveEdge = ref_onehot;
         ST_REF_LOAD: begin
            RowLoadEdge = ref_onehot;
            ArrayInData = ref_buf;
         end
         default: ;
      endcase
   end

   assign RspValid = (state == ST_RESP);
   assign RspData  = (state == ST_RESP) ? rd_data : '0;
   assign RspError = (state == ST_RESP) && rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_qram_row_sequencer.sv
`default_nettype none
// Directed scenarios for qram_row_sequencer against a small behavioural cell array.
module tb_qram_row_sequencer;

   localparam int ROWS     = 16;
   localparam int ADDR_W   = 5;
   localparam int WIDTH    = 8;
   localparam int PULSE    = 2;
   localparam int INTERVAL = 64;

   logic              Clock    = 1'b0;
   logic              Reset    = 1'b1;
   logic              ReqValid = 1'b0;
   logic              ReqWrite = 1'b0;
   logic [ADDR_W-1:0] ReqAddr  = '0;
   logic [WIDTH-1:0]  ReqData  = '0;
   logic              ReqReady, RspValid, RspError, RefreshOverrun;
   logic [WIDTH-1:0]  RspData, ArrayInData, ArrayOutData;
   logic [ROWS-1:0]   RowLoadEdge, RowDriveEdge;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [WIDTH-1:0] mem [ROWS];

   qram_row_sequencer #(
      .ROWS(ROWS), .ADDR_W(ADDR_W), .WIDTH(WIDTH),
      .PULSE_CYCLES(PULSE), .REFRESH_INTERVAL(INTERVAL)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqAddr(ReqAddr), .ReqData(ReqData),
      .RspValid(RspValid), .RspData(RspData), .RspError(RspError),
      .RowLoadEdge(RowLoadEdge), .RowDriveEdge(RowDriveEdge),
      .ArrayInData(ArrayInData), .ArrayOutData(ArrayOutData),
      .RefreshOverrun(RefreshOverrun)
   );

   always #5 Clock = ~Clock;

   // Cycle index since reset release; equals the DUT refresh counter value.
   always @(posedge Clock) cyc <= Reset ? 0 : cyc + 1;

   // Cell array: capture on load strobe, present row data while driven.
   always @(posedge Clock) begin
      for (int i = 0; i < ROWS; i++) begin
         if (Reset)               mem[i] <= 8'h30 + 8'(i);
         else if (RowLoadEdge[i]) mem[i] <= ArrayInData;
      end
   end

   always_comb begin
      ArrayOutData = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (RowDriveEdge[i]) ArrayOutData = mem[i];
      end
   end

   always @(negedge Clock) begin
      if (!Reset) begin
         checks++;
         if (!$onehot0(RowLoadEdge | RowDriveEdge) || ((|RowLoadEdge) && (|RowDriveEdge)) ||
             (RowLoadEdge == '0 && ArrayInData != '0)) begin
            errors++;
            $display("FAIL invariant cyc=%0d: load=%h drive=%h in=%h", cyc, RowLoadEdge, RowDriveEdge, ArrayInData);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_to(input int target);
      for (int n = 0; n < 300 && cyc != target; n++) @(negedge Clock);
   endtask

   task automatic test_reset();
      Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqData = '0;
      repeat (3) @(negedge Clock);
      checks++;
      if ({RowLoadEdge, RowDriveEdge, ArrayInData, RspData, RspValid, RspError, ReqReady, RefreshOverrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: load=%h drive=%h in=%h rsp=%h/%b/%b ready=%b ovr=%b, want all 0",
                  RowLoadEdge, RowDriveEdge, ArrayInData, RspData, RspValid, RspError, ReqReady, RefreshOverrun);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if (ReqReady !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", ReqReady);
      end
   endtask

   task automatic test_write(input int row, input logic [WIDTH-1:0] data, input logic [ROWS-1:0] exp_strobe);
      checks++;
      if (ReqReady !== 1'b1) begin errors++; $display("FAIL wr_ready_pre row %0d: got %b want 1", row, ReqReady); end
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = ADDR_W'(row); ReqData = data;
      @(negedge Clock);
      ReqValid = 1'b0;
      for (int k = 1; k <= PULSE; k++) begin
         checks++;
         if (RowLoadEdge !== exp_strobe || ArrayInData !== data || RowDriveEdge !== '0 || RspValid !== 1'b0) begin
            errors++;
            $display("FAIL wr_load row %0d T+%0d: load=%h in=%h drive=%h rv=%b want load=%h in=%h drive=0 rv=0",
                     row, k, RowLoadEdge, ArrayInData, RowDriveEdge, RspValid, exp_strobe, data);
         end
         @(negedge Clock);
      end
      checks++;
      if (RspValid !== 1'b1 || RspData !== '0 || RspError !== 1'b0 || ReqReady !== 1'b0 || RowLoadEdge !== '0) begin
         errors++;
         $display("FAIL wr_resp row %0d: rv=%b data=%h err=%b ready=%b load=%h want 1/00/0/0/0",
                  row, RspValid, RspData, RspError, ReqReady, RowLoadEdge);
      end
      @(negedge Clock);
      checks++;
      if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
         errors++; $display("FAIL wr_idle row %0d: rv=%b ready=%b want 0/1", row, RspValid, ReqReady);
      end
      checks++;
      if (mem[row] !== data) begin
         errors++; $display("FAIL wr_cell row %0d: cell=%h want %h", row, mem[row], data);
      end
   endtask

   task automatic test_read(input int row, input logic [ROWS-1:0] exp_strobe, input logic [WIDTH-1:0] exp_data);
      ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = ADDR_W'(row); ReqData = 8'hFF;
      @(negedge Clock);
      ReqValid = 1'b0;
      for (int k = 1; k <= PULSE; k++) begin
         checks++;
         if (RowDriveEdge !== exp_strobe || RowLoadEdge !== '0 || RspValid !== 1'b0) begin
            errors++;
            $display("FAIL rd_drive row %0d T+%0d: drive=%h load=%h rv=%b want drive=%h load=0 rv=0",
                     row, k, RowDriveEdge, RowLoadEdge, RspValid, exp_strobe);
         end
         @(negedge Clock);
      end
      checks++;
      if (RspValid !== 1'b1 || RspData !== exp_data || RspError !== 1'b0 || RowDriveEdge !== '0) begin
         errors++;
         $display("FAIL rd_resp row %0d: rv=%b data=%h err=%b drive=%h want 1/%h/0/0",
                  row, RspValid, RspData, RspError, RowDriveEdge, exp_data);
      end
      @(negedge Clock);
      checks++;
      if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
         errors++; $display("FAIL rd_idle row %0d: rv=%b ready=%b want 0/1", row, RspValid, ReqReady);
      end
   endtask

   task automatic test_addr_error(input int row);
      ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = ADDR_W'(row); ReqData = 8'h5A;
      @(negedge Clock);
      ReqValid = 1'b0;
      checks++;
      if (RspValid !== 1'b1 || RspError !== 1'b1 || RspData !== '0 || RowLoadEdge !== '0 || RowDriveEdge !== '0) begin
         errors++;
         $display("FAIL err_resp addr %0d: rv=%b err=%b data=%h load=%h drive=%h want 1/1/00/0/0",
                  row, RspValid, RspError, RspData, RowLoadEdge, RowDriveEdge);
      end
      @(negedge Clock);
      checks++;
      if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
         errors++; $display("FAIL err_idle addr %0d: rv=%b ready=%b want 0/1", row, RspValid, ReqReady);
      end
   endtask

   task automatic test_refresh_priority();
      logic [ROWS-1:0]  exp_drv  [6];
      logic [ROWS-1:0]  exp_load [6];
      logic [WIDTH-1:0] exp_in   [6];
      exp_drv  = '{16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
      exp_load = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
      exp_in   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h30};
      wait_to(INTERVAL);
      checks++;
      if (cyc != INTERVAL) begin errors++; $display("FAIL ref_wait: cyc=%0d want %0d", cyc, INTERVAL); end
      ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 5'd3; ReqData = '0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (ReqReady !== 1'b0 || RspValid !== 1'b0 || RowDriveEdge !== exp_drv[k] ||
             RowLoadEdge !== exp_load[k] || ArrayInData !== exp_in[k]) begin
            errors++;
            $display("FAIL ref_seq step %0d: ready=%b rv=%b drive=%h load=%h in=%h want 0/0/%h/%h/%h",
                     k, ReqReady, RspValid, RowDriveEdge, RowLoadEdge, ArrayInData, exp_drv[k], exp_load[k], exp_in[k]);
         end
         @(negedge Clock);
      end
      checks++;
      if (ReqReady !== 1'b1) begin errors++; $display("FAIL ref_release: ready=%b want 1", ReqReady); end
      @(negedge Clock);
      ReqValid = 1'b0;
      for (int k = 1; k <= PULSE; k++) begin
         checks++;
         if (RowDriveEdge !== 16'h0008) begin
            errors++; $display("FAIL ref_then_read T+%0d: drive=%h want 0008", k, RowDriveEdge);
         end
         @(negedge Clock);
      end
      checks++;
      if (RspValid !== 1'b1 || RspData !== 8'hA5) begin
         errors++; $display("FAIL ref_then_rsp: rv=%b data=%h want 1/a5", RspValid, RspData);
      end
      @(negedge Clock);
      checks++;
      if (mem[0] !== 8'h30 || RspValid !== 1'b0) begin
         errors++; $display("FAIL ref_restore: cell0=%h rv=%b want 30/0", mem[0], RspValid);
      end
   endtask

   task automatic test_reset_mid();
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 5'd7; ReqData = 8'h77;
      @(negedge Clock);
      ReqValid = 1'b0;
      checks++;
      if (RowLoadEdge !== 16'h0080 || ArrayInData !== 8'h77) begin
         errors++; $display("FAIL rst_mid_pre: load=%h in=%h want 0080/77", RowLoadEdge, ArrayInData);
      end
      Reset = 1'b1;
      @(negedge Clock);
      checks++;
      if ({RowLoadEdge, RowDriveEdge, ArrayInData, RspValid, ReqReady} !== '0) begin
         errors++;
         $display("FAIL rst_mid_strobes: load=%h drive=%h in=%h rv=%b ready=%b want all 0",
                  RowLoadEdge, RowDriveEdge, ArrayInData, RspValid, ReqReady);
      end
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      checks++;
      if (ReqReady !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: ready=%b want 1", ReqReady); end
      repeat (2) begin
         @(negedge Clock);
         checks++;
         if (RspValid !== 1'b0) begin errors++; $display("FAIL rst_mid_norsp: rv=%b want 0", RspValid); end
      end
   endtask

   task automatic test_refresh_walk();
      int               row;
      logic [ROWS-1:0]  exp_strobe;
      logic [WIDTH-1:0] exp_data;
      for (int k = 0; k < 17; k++) begin
         row        = k % ROWS;
         exp_strobe = 16'h0001 << row;
         exp_data   = 8'h30 + 8'(row);
         wait_to(INTERVAL * (k + 1) + 1);
         checks++;
         if (cyc != INTERVAL * (k + 1) + 1 || RowDriveEdge !== exp_strobe || RowLoadEdge !== '0) begin
            errors++;
            $display("FAIL walk_drive #%0d: cyc=%0d drive=%h load=%h want drive=%h load=0", k, cyc, RowDriveEdge, RowLoadEdge, exp_strobe);
         end
         wait_to(INTERVAL * (k + 1) + 4);
         checks++;
         if (RowLoadEdge !== exp_strobe || ArrayInData !== exp_data || RowDriveEdge !== '0) begin
            errors++;
            $display("FAIL walk_load #%0d: load=%h in=%h drive=%h want %h/%h/0", k, RowLoadEdge, ArrayInData, RowDriveEdge, exp_strobe, exp_data);
         end
      end
      checks++;
      if (RefreshOverrun !== 1'b0) begin errors++; $display("FAIL walk_no_overrun: ovr=%b want 0", RefreshOverrun); end
   endtask

   task automatic test_overrun();
      wait_to(1100);
      force dut.refresh_start = 1'b0;
      wait_to(1160);
      checks++;
      if (cyc != 1160 || RefreshOverrun !== 1'b0) begin
         errors++; $display("FAIL ovr_one_tick: cyc=%0d ovr=%b want 0", cyc, RefreshOverrun);
      end
      wait_to(1217);
      checks++;
      if (cyc != 1217 || RefreshOverrun !== 1'b1) begin
         errors++; $display("FAIL ovr_two_ticks: cyc=%0d ovr=%b want 1", cyc, RefreshOverrun);
      end
      release dut.refresh_start;
      wait_to(1300);
      checks++;
      if (RefreshOverrun !== 1'b1 || ReqReady !== 1'b1) begin
         errors++; $display("FAIL ovr_sticky: ovr=%b ready=%b want 1/1", RefreshOverrun, ReqReady);
      end
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      checks++;
      if (RefreshOverrun !== 1'b0) begin errors++; $display("FAIL ovr_reset: ovr=%b want 0", RefreshOverrun); end
      Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write(3, 8'hA5, 16'h0008);
      test_read(3, 16'h0008, 8'hA5);
      test_addr_error(20);
      test_write(15, 8'h3C, 16'h8000);
      test_read(15, 16'h8000, 8'h3C);
      test_addr_error(16);
      test_refresh_priority();
      test_reset_mid();
      test_refresh_walk();
      test_overrun();
      @(negedge Clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
